// File: rtl/tone_synth_if.sv
// Sequencer/codec-side bus for tone_synth: note request and strobe in,
// audio sample, valid pulse and busy status out.
interface tone_synth_if;
  logic [3:0]        tone;
  logic              enable;
  logic              sample_req;
  logic signed [15:0] sample;
  logic              sample_valid;
  logic              busy;

  modport master (output tone, enable, sample_req,
                  input  sample, sample_valid, busy);
  modport slave  (input  tone, enable, sample_req,
                  output sample, sample_valid, busy);
endinterface

// File: rtl/tone_synth.sv
// Square-wave tone synthesizer: 24-bit phase accumulator plus envelope FSM.
// Define TONE_SYNTH_ENVELOPE_EN for linear attack/release; otherwise notes gate on/off.
module tone_synth #(
  parameter int unsigned AMP      = 8192,
  parameter int unsigned ENV_STEP = 256
) (
  input  logic         clk,
  input  logic         resetN,
  tone_synth_if.slave  snd
);

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;

  localparam logic [15:0] AMP_W  = 16'(AMP);

  state_t      state_q, state_d;
  logic [23:0] phase_q, phase_d;
  logic [15:0] amp_q, amp_d;
  logic [15:0] sample_q, sample_d;
  logic        valid_q;
  logic        busy_q;

  // Phase increment per 48 kHz sample, chromatic scale from middle C.
  function automatic logic [23:0] inc_lut(input logic [3:0] k);
    case (k)
      4'd0:    return 24'd91446;
      4'd1:    return 24'd96884;
      4'd2:    return 24'd102645;
      4'd3:    return 24'd108748;
      4'd4:    return 24'd115215;
      4'd5:    return 24'd122067;
      4'd6:    return 24'd129326;
      4'd7:    return 24'd137015;
      4'd8:    return 24'd145162;
      4'd9:    return 24'd153791;
      4'd10:   return 24'd162939;
      4'd11:   return 24'd172627;
      default: return 24'd0;
    endcase
  endfunction

`ifdef TONE_SYNTH_ENVELOPE_EN
  localparam logic [16:0] AMP_X  = 17'(AMP);
  localparam logic [16:0] STEP_X = 17'(ENV_STEP);
  localparam logic [15:0] STEP_W = 16'(ENV_STEP);

  logic [16:0] amp_up;
  logic [15:0] amp_up_sat;
  logic [15:0] amp_dn_sat;

  // 17-bit sum so the ramp cannot wrap before it is clamped to AMP.
  assign amp_up     = {1'b0, amp_q} + STEP_X;
  assign amp_up_sat = (amp_up >= AMP_X) ? AMP_W : amp_up[15:0];
  assign amp_dn_sat = (amp_q > STEP_W) ? amp_q - STEP_W : '0;

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch can form.
    state_d = state_q;
    amp_d   = amp_q;
    case (state_q)
      IDLE, RELEASE: begin
        if (snd.enable) begin
          amp_d   = amp_up_sat;
          state_d = (amp_up_sat == AMP_W) ? SUSTAIN : ATTACK;
        end else if (state_q == RELEASE) begin
          amp_d   = amp_dn_sat;
          state_d = (amp_dn_sat == '0) ? IDLE : RELEASE;
        end
      end
      ATTACK: begin
        if (snd.enable) begin
          amp_d   = amp_up_sat;
          state_d = (amp_up_sat == AMP_W) ? SUSTAIN : ATTACK;
        end else begin
          state_d = RELEASE;
        end
      end
      SUSTAIN: begin
        if (!snd.enable) begin
          amp_d   = amp_dn_sat;
          state_d = (amp_dn_sat == '0) ? IDLE : RELEASE;
        end
      end
    endcase
  end
`else
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch can form.
    state_d = state_q;
    amp_d   = amp_q;
    case (state_q)
      IDLE: begin
        if (snd.enable) begin
          state_d = SUSTAIN;
          amp_d   = AMP_W;
        end
      end
      SUSTAIN: begin
        if (!snd.enable) begin
          state_d = IDLE;
          amp_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        amp_d   = '0;
      end
    endcase
  end
`endif

  // Phase only advances while a note was already sounding; it parks at 0 in IDLE.
  always_comb begin
    phase_d = phase_q;
    if (state_d == IDLE)
      phase_d = '0;
    else if (state_q != IDLE)
      phase_d = phase_q + inc_lut(snd.tone);
  end

  always_comb begin
    sample_d = '0;
    if (amp_d != '0)
      sample_d = phase_d[23] ? (~amp_d + 16'd1) : amp_d;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      amp_q    <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      valid_q <= snd.sample_req;
      if (snd.sample_req) begin
        state_q  <= state_d;
        phase_q  <= phase_d;
        amp_q    <= amp_d;
        sample_q <= sample_d;
        busy_q   <= (state_d != IDLE);
      end
    end
  end

  assign snd.sample       = sample_q;
  assign snd.sample_valid = valid_q;
  assign snd.busy         = busy_q;

endmodule
